// File: rtl/von_control_unit.sv
// Fetch/decode/execute sequencer driving the 3-bit-mode ALU stage.
// Define VON_SINGLE_STEP_EN to add a 'step' input and a PAUSE state.
module von_control_unit #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int START_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef VON_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] alu_ac,
    output logic [DATA_W-1:0] alu_dr,
    output logic [2:0]        alu_mode,
    output logic              alu_activate,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_e,
    output logic [ADDR_W-1:0] pc,
    output logic              e_flag,
    output logic              busy,
    output logic              halted
);

`ifdef VON_SINGLE_STEP_EN
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC,
        S_WB, S_STORE, S_HALT, S_PAUSE
    } state_t;
    localparam state_t S_NEXT = S_PAUSE;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC,
        S_WB, S_STORE, S_HALT
    } state_t;
    localparam state_t S_NEXT = S_FETCH;
`endif

    localparam logic [2:0] OP_STORE = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   ac_q, ac_d;
    logic [DATA_W-1:0]   dr_q, dr_d;
    logic                e_q, e_d;
    logic                act_q, act_d;

    logic [2:0]          opcode;
    logic [ADDR_W-1:0]   op_addr;

    assign opcode  = ir_q[DATA_W-1 -: 3];
    assign op_addr = ir_q[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= ADDR_W'(START_PC);
            ir_q    <= '0;
            ac_q    <= '0;
            dr_q    <= '0;
            e_q     <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
            dr_q    <= dr_d;
            e_q     <= e_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HALT)       state_d = S_HALT;
                else if (opcode == OP_STORE) state_d = S_STORE;
                else                         state_d = S_READ;
            end
            S_READ:   state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_NEXT;
            S_STORE:  state_d = S_NEXT;
            S_HALT:   state_d = S_HALT;
`ifdef VON_SINGLE_STEP_EN
            S_PAUSE:  if (step) state_d = S_FETCH;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Register updates; activate is set in READ so it is high for all of EXEC.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        ac_d  = ac_q;
        dr_d  = dr_q;
        e_d   = e_q;
        act_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d = mem_rdata;
                pc_d = pc_q + ADDR_W'(1);
            end
            S_READ: begin
                dr_d  = mem_rdata;
                act_d = 1'b1;
            end
            S_WB: begin
                ac_d = alu_result;
                e_d  = alu_e;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr = pc_q;
        mem_we   = 1'b0;
        busy     = 1'b1;
        halted   = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_READ:  mem_addr = op_addr;
            S_STORE: begin
                mem_addr = op_addr;
                mem_we   = 1'b1;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
`ifdef VON_SINGLE_STEP_EN
            S_PAUSE: busy = 1'b0;
`endif
            default: ;
        endcase
    end

    assign mem_wdata    = ac_q;
    assign alu_ac       = ac_q;
    assign alu_dr       = dr_q;
    assign alu_mode     = opcode;
    assign alu_activate = act_q;
    assign pc           = pc_q;
    assign e_flag       = e_q;

endmodule

// File: tb/tb_von_control_unit.sv
// Scoreboard bench: an instruction-level model predicts ALU, store and halt events.
module tb_von_control_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] alu_ac;
    logic [7:0] alu_dr;
    logic [2:0] alu_mode;
    logic       alu_activate;
    logic [7:0] alu_result;
    logic       alu_e;
    logic [4:0] pc;
    logic       e_flag;
    logic       busy;
    logic       halted;
`ifdef VON_SINGLE_STEP_EN
    logic       step;
    localparam int PS = 1;
`else
    localparam int PS = 0;
`endif

    von_control_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef VON_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we),
        .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_mode(alu_mode),
        .alu_activate(alu_activate), .alu_result(alu_result),
        .alu_e(alu_e), .pc(pc), .e_flag(e_flag),
        .busy(busy), .halted(halted)
    );

    typedef struct {
        int k; int t; int a; int ac; int dr; int pc; int e;
    } ev_t;

    ev_t        q[$];
    logic [7:0] mem [32];
    logic [7:0] prog [32];
    logic       ld;
    int         vec, mis, cyc, base, wcnt;
    logic       hp, chk_t;
    bit         exp_halt;
    int         exp_pc, exp_ac, exp_e;

    // Environment ALU: 0 add, 1 and, 2 or, 3 xor, 4 load, 6 sub (borrow in e).
    function automatic logic [8:0] alu_f(input logic [2:0] md,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (md)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a & b};
            3'd2: return {1'b0, a | b};
            3'd3: return {1'b0, a ^ b};
            3'd4: return {1'b0, b};
            3'd6: return {a < b, 8'(a - b)};
            default: return {1'b0, a};
        endcase
    endfunction

    assign mem_rdata = mem[mem_addr];
    assign {alu_e, alu_result} = alu_f(alu_mode, alu_ac, alu_dr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial forever begin
        @(posedge clk);
        if (ld) begin
            for (int i = 0; i < 32; i++) mem[i] <= prog[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push(input int k, input int t, input int a,
                                 input int ac, input int dr, input int p,
                                 input int e);
        ev_t ev;
        ev.k = k; ev.t = t; ev.a = a; ev.ac = ac;
        ev.dr = dr; ev.pc = p; ev.e = e;
        q.push_back(ev);
    endfunction

    // Instruction-set model: runs prog[] and lists the expected events.
    function automatic void model();
        logic [7:0] m [32];
        logic [4:0] p;
        logic [7:0] a, ins, d;
        logic [8:0] r;
        logic       ec;
        int         t;
        m = prog; p = 5'd0; a = 8'd0; ec = 1'b0; t = 0;
        exp_halt = 1'b0;
        for (int n = 0; n < 40; n++) begin
            ins = m[p];
            p = p + 5'd1;
            if (ins[7:5] == 3'b111) begin
                push(2, t + 2, 0, int'(a), 0, int'(p), int'(ec));
                exp_halt = 1'b1;
                break;
            end else if (ins[7:5] == 3'b101) begin
                push(1, t + 2, int'(ins[4:0]), int'(a), 0, int'(p), int'(ec));
                m[ins[4:0]] = a;
                t += 3 + PS;
            end else begin
                d = m[ins[4:0]];
                push(0, t + 3, int'(ins[7:5]), int'(a), int'(d), int'(p), int'(ec));
                r = alu_f(ins[7:5], a, d);
                a = r[7:0];
                ec = r[8];
                t += 5 + PS;
            end
        end
        exp_pc = int'(p); exp_ac = int'(a); exp_e = int'(ec);
    endfunction

    task automatic take(input int k, input int a, input int ac, input int dr);
        ev_t ev;
        if (q.size() == 0) begin
            vec++;
            mis++;
            $display("FAIL unexpected event kind %0d: got one, expected none", k);
        end else begin
            ev = q.pop_front();
            chk("ev.kind", k, ev.k);
            if (chk_t) chk("ev.cycle", cyc - base, ev.t);
            chk("ev.addr_mode", a, ev.a);
            chk("ev.ac", ac, ev.ac);
            chk("ev.dr", dr, ev.dr);
            chk("ev.pc", pc, ev.pc);
            chk("ev.e", e_flag, ev.e);
        end
    endtask

    initial begin
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hp = 1'b0;
            end else begin
                if (alu_activate)
                    take(0, int'(alu_mode), int'(alu_ac), int'(alu_dr));
                if (mem_we) begin
                    wcnt++;
                    take(1, int'(mem_addr), int'(mem_wdata), 0);
                end
                if (halted && !hp) begin
                    take(2, 0, int'(alu_ac), 0);
                    chk("halt.busy", busy, 0);
                end
                hp = halted;
            end
        end
    end

    task automatic begin_prog();
        rst_n = 1'b0;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        rst_n = 1'b1;
        model();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = cyc;
    endtask

    task automatic run_prog();
        int n;
        begin_prog();
        n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            vec++;
            mis++;
            $display("FAIL timeout: %0d events pending, expected 0", q.size());
        end else if (exp_halt) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (6) @(negedge clk);
            chk("post.halted", halted, 1);
            chk("post.busy", busy, 0);
            chk("post.pc", pc, exp_pc);
            chk("post.ac", alu_ac, exp_ac);
            chk("post.e", e_flag, exp_e);
        end
        #1;
        if (!exp_halt) rst_n = 1'b0;
        q.delete();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    initial begin
        int n, w0;
        vec = 0; mis = 0; base = 0;
        rst_n = 1'b0; start = 1'b0; ld = 1'b0; chk_t = 1'b1;
`ifdef VON_SINGLE_STEP_EN
        step = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.halted", halted, 0);
        chk("rst.act", alu_activate, 0);
        chk("rst.we", mem_we, 0);
        chk("rst.mode", alu_mode, 0);
        chk("rst.pc", pc, 0);
        chk("rst.e", e_flag, 0);
        chk("rst.ac", alu_ac, 0);
        chk("rst.dr", alu_dr, 0);

        clear_prog();
        prog[0] = 8'h0A; prog[10] = 8'h05; prog[1] = 8'hE0;
        run_prog();
        chk("add.ac", alu_ac, 8'h05);
        chk("add.e", e_flag, 0);

        clear_prog();
        prog[0] = 8'h88; prog[1] = 8'h09; prog[2] = 8'hE0;
        prog[8] = 8'hFF; prog[9] = 8'h01;
        run_prog();
        chk("carry.ac", alu_ac, 8'h00);
        chk("carry.e", e_flag, 1);

        clear_prog();
        prog[0] = 8'h88; prog[1] = 8'hB4; prog[2] = 8'hE0; prog[8] = 8'h3C;
        w0 = wcnt;
        run_prog();
        chk("store.mem20", mem[20], 8'h3C);
        chk("store.pulses", wcnt - w0, 1);

        // AC = 0x70 + 0x70 = 0xE0 is stored over addr 0, so the wrap halts.
        for (int i = 0; i < 32; i++) prog[i] = 8'h70;
        prog[0] = 8'h90; prog[1] = 8'h10; prog[2] = 8'hA0; prog[31] = 8'h9F;
        run_prog();
        chk("wrap.halted", halted, 1);
        chk("wrap.pc", pc, 1);

        clear_prog();
        prog[0] = 8'h0A; prog[10] = 8'h05; prog[1] = 8'hB4;
        prog[2] = 8'hE0; prog[20] = 8'h77;
        begin_prog();
        n = 0;
        while (!alu_activate && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort.reached_exec", alu_activate, 1);
        #2 rst_n = 1'b0;
        #1;
        w0 = wcnt;
        chk("abort.act", alu_activate, 0);
        chk("abort.busy", busy, 0);
        chk("abort.pc", pc, 0);
        chk("abort.ac", alu_ac, 0);
        chk("abort.dr", alu_dr, 0);
        chk("abort.mode", alu_mode, 0);
        chk("abort.we", mem_we, 0);
        repeat (10) @(negedge clk);
        chk("abort.mem20", mem[20], 8'h77);
        chk("abort.pulses", wcnt - w0, 0);
        q.delete();

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 32; i++)
                prog[i] = {3'($urandom_range(0, 6)), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 3) != 0)
                prog[$urandom_range(1, 31)] = {3'b111, 5'($urandom_range(0, 31))};
            run_prog();
        end

`ifdef VON_SINGLE_STEP_EN
        clear_prog();
        prog[0] = 8'h88; prog[1] = 8'h89; prog[2] = 8'hE0;
        prog[8] = 8'h11; prog[9] = 8'h22;
        step = 1'b0;
        chk_t = 1'b0;
        begin_prog();
        repeat (12) @(negedge clk);
        chk("step1.busy", busy, 0);
        chk("step1.pc", pc, 1);
        chk("step1.ac", alu_ac, 8'h11);
        chk("step1.pending", q.size(), 2);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (12) @(negedge clk);
        chk("step2.busy", busy, 0);
        chk("step2.pc", pc, 2);
        chk("step2.ac", alu_ac, 8'h22);
        chk("step2.pending", q.size(), 1);
        step = 1'b1;
        repeat (8) @(negedge clk);
        chk("step3.halted", halted, 1);
        chk("step3.pending", q.size(), 0);
        chk_t = 1'b1;
        q.delete();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
